// File: rtl/pipeline_array_pkg.sv
// Shared constants and types for the N-channel pipeline array and its arbiter.
package pipeline_array_pkg;

  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 3;
  localparam int DEF_ADD_CONST = 1;
  localparam int DEF_ARB_RR    = 1;

  localparam int CH_IDX_W = $clog2(DEF_NUM_CH);

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/pipeline_array_rr_arbiter.sv
// One-hot arbiter for the shared adder: round-robin from last_grant+1, or
// fixed priority with the lowest requesting index winning.
module rr_arbiter
  import pipeline_array_pkg::*;
#(
  parameter int        NUM_CH = DEF_NUM_CH,
  parameter arb_mode_e MODE   = ARB_RR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0]  r_lastGrant;
  logic [NUM_CH-1:0] w_grant;
  logic [IDX_W-1:0]  w_grantIdx;
  logic              w_anyGrant;

  // Round-robin searches indices above last_grant first, then wraps to the bottom.
  always_comb begin
    w_grant    = '0;
    w_grantIdx = '0;
    w_anyGrant = 1'b0;
    if (MODE == ARB_RR) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_anyGrant && req[c] && (c > int'(r_lastGrant))) begin
          w_anyGrant = 1'b1;
          w_grantIdx = IDX_W'(c);
          w_grant[c] = 1'b1;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_anyGrant && req[c]) begin
        w_anyGrant = 1'b1;
        w_grantIdx = IDX_W'(c);
        w_grant[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastGrant <= IDX_W'(NUM_CH - 1);
    end else if (w_anyGrant) begin
      r_lastGrant <= w_grantIdx;
    end
  end

  assign grant = w_grant;

endmodule

// File: rtl/pipeline_array.sv
// N-channel pipeline array: per-channel s0 capture, one shared adder feeding s1,
// then plain delay stages. Each channel has its own flush and upstream stall.
module pipeline_array
  import pipeline_array_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADD_CONST = DEF_ADD_CONST,
  parameter int ARB_RR    = DEF_ARB_RR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        flush,
  output logic [NUM_CH-1:0]        stall,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid
);

  localparam arb_mode_e ARB_MODE = (ARB_RR != 0) ? pipeline_array_pkg::ARB_RR : ARB_FIXED;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (ARB_MODE)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (w_req),
    .grant (w_grant)
  );

  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic              w_load;

    // A flushed channel neither requests nor stalls, so its producer may advance.
    assign w_req[c] = r_valid[0] & ~flush[c];
    assign stall[c] = r_valid[0] & ~w_grant[c] & ~flush[c];
    assign w_load   = in_valid[c] & ~stall[c] & ~flush[c];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_valid <= '0;
      end else if (flush[c]) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= w_load | (r_valid[0] & ~w_grant[c]);
        r_valid[1] <= w_grant[c];
        for (int s = 2; s < DEPTH; s++) begin
          r_valid[s] <= r_valid[s-1];
        end
      end
    end

    // Data registers ignore flush; only the valid bits are cleared.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s < DEPTH; s++) begin
          r_data[s] <= '0;
        end
      end else begin
        if (w_load) begin
          r_data[0] <= in_data[c*DATA_W +: DATA_W];
        end
        if (w_grant[c]) begin
          r_data[1] <= r_data[0] + DATA_W'(ADD_CONST);
        end
        for (int s = 2; s < DEPTH; s++) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end

    assign out_data[c*DATA_W +: DATA_W] = r_data[DEPTH-1];
    assign out_valid[c]                 = r_valid[DEPTH-1];
  end

endmodule

// File: tb/tb_pipeline_array.sv
// Drives a round-robin and a fixed-priority pipeline_array side by side and
// compares stall, out_valid and out_data against a transaction-level model.
module tb_pipeline_array;
  import pipeline_array_pkg::*;

  localparam int NCH  = 2;
  localparam int DW   = 32;
  localparam int DEP  = 3;
  localparam int ADDC = 1;
  localparam int NDUT = 2;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  typedef bit chbits_t [NCH];

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic [NCH*DW-1:0] inData  [NDUT];
  logic [NCH-1:0]    inValid [NDUT];
  logic [NCH-1:0]    flush   [NDUT];

  wire [NCH-1:0]    stallRr, stallFp, outValidRr, outValidFp;
  wire [NCH*DW-1:0] outDataRr, outDataFp;

  pipeline_array #(
    .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .ADD_CONST(ADDC), .ARB_RR(1)
  ) dutRr (
    .clk(clk), .reset(reset), .in_data(inData[0]), .in_valid(inValid[0]),
    .flush(flush[0]), .stall(stallRr), .out_data(outDataRr), .out_valid(outValidRr)
  );

  pipeline_array #(
    .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .ADD_CONST(ADDC), .ARB_RR(0)
  ) dutFp (
    .clk(clk), .reset(reset), .in_data(inData[1]), .in_valid(inValid[1]),
    .flush(flush[1]), .stall(stallFp), .out_data(outDataFp), .out_valid(outValidFp)
  );

  always #5 clk = ~clk;

  // Reference model: words waiting for the adder, and results scheduled for output.
  bit            mS0v [NDUT][NCH];
  logic [DW-1:0] mS0d [NDUT][NCH];
  int            mLast [NDUT];
  pend_t         mQ [NDUT][NCH][$];
  bit            mZero [NDUT][NCH];
  int            cyc;

  int            checks;
  int            failures;

  int            actProb   [NDUT][NCH];
  int            wordsLeft [NDUT][NCH];
  logic [DW-1:0] seqNext   [NDUT][NCH];
  bit            seqMode;
  int            flushProb;
  bit            lastStall [NDUT][NCH];

  function automatic logic [NCH-1:0] dutStall(input int d);
    return (d == 0) ? stallRr : stallFp;
  endfunction

  function automatic logic [NCH-1:0] dutValid(input int d);
    return (d == 0) ? outValidRr : outValidFp;
  endfunction

  function automatic logic [NCH*DW-1:0] dutData(input int d);
    return (d == 0) ? outDataRr : outDataFp;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < NDUT; d++) begin
      mLast[d] = NCH - 1;
      for (int c = 0; c < NCH; c++) begin
        mS0v[d][c]      = 1'b0;
        mS0d[d][c]      = '0;
        mZero[d][c]     = 1'b1;
        lastStall[d][c] = 1'b0;
        mQ[d][c].delete();
      end
    end
  endtask

  // Grant from rotating priority (d=0) or lowest index (d=1).
  task automatic modelComb(input int d, output int g, output chbits_t st);
    bit req [NCH];
    int cand;
    g = -1;
    for (int c = 0; c < NCH; c++) req[c] = mS0v[d][c] && !flush[d][c];
    if (d == 0) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = (mLast[d] + k) % NCH;
        if (g < 0 && req[cand]) g = cand;
      end
    end else begin
      for (int c = 0; c < NCH; c++) if (g < 0 && req[c]) g = c;
    end
    for (int c = 0; c < NCH; c++) st[c] = mS0v[d][c] && (g != c) && !flush[d][c];
  endtask

  task automatic modelEdge(input int d, input int g, input chbits_t st);
    logic [NCH*DW-1:0] din;
    din = inData[d];
    for (int c = 0; c < NCH; c++) begin
      if (flush[d][c]) begin
        mS0v[d][c] = 1'b0;
        mQ[d][c].delete();
      end else begin
        if (g == c) begin
          mQ[d][c].push_back('{due: cyc + DEP - 2, data: DW'(mS0d[d][c] + DW'(ADDC))});
          mZero[d][c] = 1'b0;
        end
        if (inValid[d][c] && !st[c]) begin
          mS0v[d][c] = 1'b1;
          mS0d[d][c] = din[c*DW +: DW];
        end else if (g == c) begin
          mS0v[d][c] = 1'b0;
        end
      end
      lastStall[d][c] = st[c];
    end
    if (g >= 0) mLast[d] = g;
  endtask

  task automatic checkReset(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s d%0d out_valid", tag, d), 64'(dutValid(d)), 64'(0));
      checkOutput($sformatf("%s d%0d out_data", tag, d), 64'(dutData(d)), 64'(0));
      checkOutput($sformatf("%s d%0d stall", tag, d), 64'(dutStall(d)), 64'(0));
    end
  endtask

  task automatic checkOutputs();
    logic [NCH*DW-1:0] all;
    logic [NCH-1:0]    vld;
    bit                expV;
    for (int d = 0; d < NDUT; d++) begin
      all = dutData(d);
      vld = dutValid(d);
      for (int c = 0; c < NCH; c++) begin
        expV = (mQ[d][c].size() > 0) && (mQ[d][c][0].due == cyc);
        checkOutput($sformatf("d%0d c%0d out_valid", d, c), 64'(vld[c]), 64'(expV));
        if (expV) begin
          checkOutput($sformatf("d%0d c%0d out_data", d, c), 64'(all[c*DW +: DW]), 64'(mQ[d][c][0].data));
          void'(mQ[d][c].pop_front());
        end else if (mZero[d][c]) begin
          checkOutput($sformatf("d%0d c%0d out_data idle", d, c), 64'(all[c*DW +: DW]), 64'(0));
        end
      end
    end
  endtask

  // Called just after a falling edge; the producer holds its word while stalled.
  task automatic applyStimulus();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < NCH; c++) begin
        flush[d][c] = ($urandom_range(99) < flushProb);
        if (!lastStall[d][c]) begin
          if (wordsLeft[d][c] != 0 && $urandom_range(99) < actProb[d][c]) begin
            inValid[d][c] = 1'b1;
            inData[d][c*DW +: DW] = seqMode ? seqNext[d][c] :
                                    (($urandom_range(7) == 0) ? {DW{1'b1}} : DW'($urandom));
            seqNext[d][c] = seqNext[d][c] + 1;
            if (wordsLeft[d][c] > 0) wordsLeft[d][c]--;
          end else begin
            inValid[d][c] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    int             g [NDUT];
    chbits_t        st [NDUT];
    logic [NCH-1:0] ds;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      modelComb(d, g[d], st[d]);
      ds = dutStall(d);
      for (int c = 0; c < NCH; c++)
        checkOutput($sformatf("d%0d c%0d stall", d, c), 64'(ds[c]), 64'(st[d][c]));
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < NDUT; d++) modelEdge(d, g[d], st[d]);
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      applyStimulus();
      tick();
    end
  endtask

  task automatic setChan(input int d, input int c, input int prob, input int words, input logic [DW-1:0] start);
    actProb[d][c]   = prob;
    wordsLeft[d][c] = words;
    seqNext[d][c]   = start;
  endtask

  task automatic quiet();
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < NCH; c++) setChan(d, c, 0, 0, '0);
    flushProb = 0;
  endtask

  // Async reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic pulseReset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    checkReset(tag);
    modelReset();
    @(negedge clk);
    checkReset({tag, " held"});
    reset = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    seqMode   = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      inData[d]  = '0;
      inValid[d] = '0;
      flush[d]   = '0;
    end
    quiet();
    modelReset();

    #2;
    checkReset("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(5);

    $display("[TB] single stream on ch0");
    setChan(0, 0, 100, 3, 32'h10);
    run(8);

    $display("[TB] round-robin contention after reset");
    pulseReset("pre-contention reset");
    setChan(0, 0, 100, 6, 32'h100);
    setChan(0, 1, 100, 6, 32'h200);
    $display("[TB] fixed priority starving ch1");
    setChan(1, 0, 100, 6, 32'h1000);
    setChan(1, 1, 100, 1, 32'h55);
    run(20);

    $display("[TB] flush in flight and while stalled");
    setChan(0, 0, 100, -1, 32'h300);
    setChan(0, 1, 100, -1, 32'h400);
    setChan(1, 0, 100, -1, 32'h2000);
    setChan(1, 1, 100, 1, 32'h66);
    run(4);
    applyStimulus();
    flush[0][1] = 1'b1;
    flush[1][1] = 1'b1;
    tick();
    run(4);
    quiet();
    run(6);

    $display("[TB] mid-stream reset");
    setChan(0, 0, 100, -1, 32'h500);
    setChan(0, 1, 100, -1, 32'h600);
    run(5);
    applyStimulus();
    pulseReset("mid-stream reset");
    run(12);
    quiet();
    run(6);

    $display("[TB] randomized traffic");
    seqMode = 1'b0;
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < NCH; c++) setChan(d, c, $urandom_range(100, 40), -1, '0);
    flushProb = 4;
    run(400);
    quiet();
    run(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
